exec_unit: RTL

Execute/write-back stage of tinylabcpu, directly downstream of the register-file read stage. It accepts the two read operands and their valid strobe from the register group and performs the ALU operation. Single-cycle ops finish in one EXEC cycle; MUL uses a 16-step shift-add sequence. It then drives the data word and one-hot write enable back into the register file for write-back.

---
 rtl/exec_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/exec_unit.sv
// tinylabcpu execute/write-back stage: latches operands from register read,
// runs single-cycle ALU ops or a 16-step shift-add MUL, then writes back one-hot.
module exec_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic [3:0]  op,
  input  logic [1:0]  rd,
  input  logic [15:0] rd_q,
  input  logic [15:0] rs_q,
  output logic [15:0] d_out,
  output logic [3:0]  reg_en,
  output logic        flag_z,
  output logic        flag_c,
  output logic        flag_n,
  output logic        busy,
  output logic        en_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MUL  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  localparam logic [3:0] OP_MOV = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_SHR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  logic [1:0]  state_q, state_d;
  logic [3:0]  op_q;
  logic [1:0]  rdst_q;
  logic [15:0] a_q, b_q;
  logic [31:0] acc_q, mcand_q;
  logic [15:0] mplier_q;
  logic [4:0]  cnt_q;

  logic [15:0] dout_q;
  logic [3:0]  regen_q;
  logic        enout_q, fz_q, fc_q, fn_q;

  logic [16:0] sum17, dif17;
  logic [31:0] prod_nxt;
  logic [15:0] res;
  logic        res_c, wr, upd, go_wb;

  assign sum17    = {1'b0, a_q} + {1'b0, b_q};
  assign dif17    = {1'b0, a_q} - {1'b0, b_q};
  // Last shift-add step folds in here so MUL results are ready on the edge into WB.
  assign prod_nxt = acc_q + (mplier_q[0] ? mcand_q : 32'd0);

  assign go_wb = (state_q == S_EXEC) || ((state_q == S_MUL) && (cnt_q == 5'd15));

  always_comb begin
    res   = 16'd0;
    res_c = 1'b0;
    wr    = 1'b1;
    upd   = 1'b1;
    case (op_q)
      OP_MOV: res = b_q;
      OP_ADD: begin res = sum17[15:0]; res_c = sum17[16]; end
      OP_SUB: begin res = dif17[15:0]; res_c = dif17[16]; end
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~b_q;
      OP_SHL: begin res = {a_q[14:0], 1'b0}; res_c = a_q[15]; end
      OP_SHR: begin res = {1'b0, a_q[15:1]}; res_c = a_q[0]; end
      OP_MUL: begin res = prod_nxt[15:0]; res_c = |prod_nxt[31:16]; end
      OP_CMP: begin res = dif17[15:0]; res_c = dif17[16]; wr = 1'b0; end
      default: begin wr = 1'b0; upd = 1'b0; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (en_in) state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
      S_EXEC: state_d = S_WB;
      S_MUL:  if (cnt_q == 5'd15) state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 4'd0;
      rdst_q   <= 2'd0;
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 16'd0;
      cnt_q    <= 5'd0;
      dout_q   <= 16'd0;
      regen_q  <= 4'd0;
      enout_q  <= 1'b0;
      fz_q     <= 1'b0;
      fc_q     <= 1'b0;
      fn_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        // Upstream zeroes its operands once en_in drops, so capture them now.
        S_IDLE: if (en_in) begin
          op_q     <= op;
          rdst_q   <= rd;
          a_q      <= rd_q;
          b_q      <= rs_q;
          acc_q    <= 32'd0;
          mcand_q  <= {16'd0, rd_q};
          mplier_q <= rs_q;
          cnt_q    <= 5'd0;
        end
        S_MUL: begin
          acc_q    <= prod_nxt;
          mcand_q  <= {mcand_q[30:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[15:1]};
          cnt_q    <= cnt_q + 5'd1;
        end
        default: ;
      endcase

      if (go_wb) begin
        dout_q  <= wr ? res : 16'd0;
        regen_q <= wr ? (4'b0001 << rdst_q) : 4'd0;
        enout_q <= 1'b1;
        if (upd) begin
          fz_q <= (res == 16'd0);
          fc_q <= res_c;
          fn_q <= res[15];
        end
      end else if (state_q == S_WB) begin
        dout_q  <= 16'd0;
        regen_q <= 4'd0;
        enout_q <= 1'b0;
      end
    end
  end

  assign d_out  = dout_q;
  assign reg_en = regen_q;
  assign en_out = enout_q;
  assign flag_z = fz_q;
  assign flag_c = fc_q;
  assign flag_n = fn_q;
  assign busy   = (state_q != S_IDLE);

endmodule
